// File: rtl/uncache_access_unit_pkg.sv
// uncache_access_unit_pkg: shared state/size encodings and watchdog default for the uncached access unit
package uncache_access_unit_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam int TIMEOUT_CYCLES_DEF = 1024;
endpackage

// File: rtl/uncache_access_unit_watchdog.sv
// uncache_watchdog: busy-cycle counter, expiry compare and stale-response pending flag (UNCACHE_TIMEOUT_EN builds only)
module uncache_watchdog
   import uncache_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   input  logic waiting,
   input  logic data_ok,
   output logic expire,
   output logic pending
);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] cnt;
   assign expire = busy & (cnt == TO_W'(TIMEOUT_CYCLES - 1));
   // count cycles spent in REQ/WAIT, clear whenever the unit is not busy
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else cnt <= busy ? cnt + 1'b1 : '0;
   // an abandoned transaction whose address was accepted still owes a data_ok
   always_ff @(posedge clk)
      if (rst) pending <= 1'b0;
      else if (data_ok) pending <= 1'b0;
      else if (expire & waiting) pending <= 1'b1;
endmodule

// File: rtl/uncache_access_unit.sv
// uncache_access_unit: single-outstanding uncached load/store over the SRAM-like bus; optional watchdog via UNCACHE_TIMEOUT_EN
module uncache_access_unit
   import uncache_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_paddr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata
);
   state_t state;
   logic   drop, err_q, expire, pend;
`ifdef UNCACHE_TIMEOUT_EN
   uncache_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
      .clk     (clk),
      .rst     (rst),
      .busy    (state == REQ || state == WAIT),
      .waiting (state == WAIT),
      .data_ok (bus_data_ok),
      .expire  (expire),
      .pending (pend)
   );
`else
   assign expire = 1'b0;
   assign pend   = 1'b0;
`endif
   assign req_ready  = (state == IDLE) & ~pend;
   assign resp_valid = (state == DONE) & ~flush;
   assign resp_err   = err_q;
   // request/bus/response sequencing; the bus_* registers double as the request latch
   always_ff @(posedge clk)
      if (rst) begin
         state      <= IDLE;
         drop       <= 1'b0;
         err_q      <= 1'b0;
         resp_rdata <= '0;
         bus_req    <= 1'b0;
         bus_wr     <= 1'b0;
         bus_size   <= '0;
         bus_addr   <= '0;
         bus_wstrb  <= '0;
         bus_wdata  <= '0;
      end else
         case (state)
            IDLE: begin
               drop <= 1'b0;
               if (req_valid & req_ready & ~flush) begin
                  state     <= REQ;
                  bus_req   <= 1'b1;
                  bus_wr    <= req_we;
                  bus_size  <= req_size;
                  bus_addr  <= req_paddr;
                  bus_wstrb <= req_we ? req_wstrb : 4'h0;
                  bus_wdata <= req_wdata;
               end
            end
            REQ:
               if (bus_addr_ok) begin
                  bus_req <= 1'b0;
                  if (bus_data_ok) begin
                     state      <= flush ? IDLE : DONE;
                     resp_rdata <= bus_wr ? 32'h0 : bus_rdata;
                  end else begin
                     state <= WAIT;
                     drop  <= flush;
                  end
               end else if (flush) begin
                  bus_req <= 1'b0;
                  state   <= IDLE;
               end else if (expire) begin
                  bus_req    <= 1'b0;
                  state      <= DONE;
                  err_q      <= 1'b1;
                  resp_rdata <= 32'h0;
               end
            WAIT:
               if (bus_data_ok) begin
                  state      <= (drop | flush) ? IDLE : DONE;
                  resp_rdata <= bus_wr ? 32'h0 : bus_rdata;
                  drop       <= 1'b0;
               end else if (expire) begin
                  state      <= (drop | flush) ? IDLE : DONE;
                  err_q      <= ~(drop | flush);
                  resp_rdata <= 32'h0;
                  drop       <= 1'b0;
               end else
                  drop <= drop | flush;
            DONE: begin
               state <= IDLE;
               err_q <= 1'b0;
            end
         endcase
endmodule
